// File: rtl/sd_block_spi_pkg.sv
// ---------------------------------------------------------------------------
// sd_block_spi_pkg
// Shared definitions for the SD block transfer engine: FSM state encoding,
// SPI-mode command opcodes, data tokens, the data-response mask and a helper
// that produces the 6-byte command frame one byte at a time.
// ---------------------------------------------------------------------------
package sd_block_spi_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CMD   = 4'd1,
    ST_R1    = 4'd2,
    ST_RTOK  = 4'd3,
    ST_RDATA = 4'd4,
    ST_RCRC  = 4'd5,
    ST_WGAP  = 4'd6,
    ST_WTOK  = 4'd7,
    ST_WDATA = 4'd8,
    ST_WCRC  = 4'd9,
    ST_WRESP = 4'd10,
    ST_WBUSY = 4'd11,
    ST_FIN   = 4'd12
  } state_e;

  localparam logic [7:0]  CMD17_OP     = 8'h51;  // READ_SINGLE_BLOCK
  localparam logic [7:0]  CMD24_OP     = 8'h58;  // WRITE_BLOCK
  localparam logic [7:0]  START_TOKEN  = 8'hFE;  // single-block data start token
  localparam logic [7:0]  IDLE_BYTE    = 8'hFF;
  localparam logic [7:0]  R1_READY     = 8'h00;
  localparam logic [7:0]  DRESP_MASK   = 8'h1F;
  localparam logic [7:0]  DRESP_ACCEPT = 8'h05;
  localparam logic [15:0] R1_POLL_MAX  = 16'd8;  // NCR window for the R1 response

  // Byte idx of the command frame {opcode, 9'b0, block, CRC}. The CRC byte is
  // sent as FF: the card ignores CRC in SPI mode once initialised.
  function automatic logic [7:0] cmd_byte(input logic [2:0]  idx,
                                          input logic        is_write,
                                          input logic [22:0] blk);
    logic [31:0] arg;
    arg = {9'h000, blk};
    case (idx)
      3'd0:    cmd_byte = is_write ? CMD24_OP : CMD17_OP;
      3'd1:    cmd_byte = arg[31:24];
      3'd2:    cmd_byte = arg[23:16];
      3'd3:    cmd_byte = arg[15:8];
      3'd4:    cmd_byte = arg[7:0];
      default: cmd_byte = IDLE_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/sd_block_spi_xfer.sv
// ---------------------------------------------------------------------------
// spi_byte_xfer
// One SPI mode-0 byte exchange per start pulse: sclk idles low, MOSI changes on
// the falling edge (first bit presented before the first rising edge), MISO is
// sampled on the rising edge, MSB first. Each sclk half-period is CLK_DIV clk.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   start_i     begin a byte (ignored while a byte is in flight)
//   tx_i        byte to send, captured with start_i
//   rx_o        last received byte, valid when done_o pulses
//   done_o      1-clk pulse after the 8th falling edge
//   sclk_o      SPI clock
//   mosi_o      SPI data out, high when idle
//   miso_i      SPI data in
// ---------------------------------------------------------------------------
module spi_byte_xfer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] tx_i,
  output logic [7:0] rx_o,
  output logic       done_o,
  output logic       sclk_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             busy_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_q;
  logic             sclk_q;
  logic             mosi_q;
  logic [7:0]       sh_q;
  logic [7:0]       rx_q;
  logic             done_q;

  // Clock divider, bit counter and shift registers for one byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      div_q  <= '0;
      bit_q  <= 3'd0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b1;
      sh_q   <= 8'hFF;
      rx_q   <= 8'h00;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (start_i) begin
          busy_q <= 1'b1;
          div_q  <= '0;
          bit_q  <= 3'd0;
          sclk_q <= 1'b0;
          sh_q   <= tx_i;
          mosi_q <= tx_i[7];
        end
      end else if (div_q == DIV_LAST) begin
        div_q <= '0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
          rx_q   <= {rx_q[6:0], miso_i};
        end else begin
          sclk_q <= 1'b0;
          if (bit_q == 3'd7) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            mosi_q <= 1'b1;
          end else begin
            bit_q  <= bit_q + 3'd1;
            sh_q   <= {sh_q[6:0], 1'b1};
            mosi_q <= sh_q[6];
          end
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  assign rx_o   = rx_q;
  assign done_o = done_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;

endmodule

// File: rtl/sd_block_spi.sv
// ---------------------------------------------------------------------------
// sd_block_spi
// Executes single-block SD reads (CMD17) and writes (CMD24) in SPI mode,
// moving data between the card and the shared 512x8 block buffer.
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   card_ready            card initialisation complete
//   read_spi / write_spi  level requests (write wins when both are high)
//   block                 SDHC block number
//   busy                  not accepting requests / transfer in progress
//   err                   last transfer failed; cleared on next capture
//   buf_addr/wdata/we     block buffer write side and address
//   buf_rdata             buffer read data, one clk after buf_addr
//   sd_cs_n/sclk/mosi/miso SPI bus to the card
// ---------------------------------------------------------------------------
module sd_block_spi
  import sd_block_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter logic [15:0] RESP_TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_ready,
  input  logic        read_spi,
  input  logic        write_spi,
  input  logic [22:0] block,
  output logic        busy,
  output logic        err,
  output logic [8:0]  buf_addr,
  output logic [7:0]  buf_wdata,
  output logic        buf_we,
  input  logic [7:0]  buf_rdata,
  output logic        sd_cs_n,
  output logic        sd_sclk,
  output logic        sd_mosi,
  input  logic        sd_miso
);

  state_e      state_q;
  logic        is_wr_q;
  logic [22:0] block_q;
  logic        err_q;
  logic        cs_n_q;
  logic        buf_we_q;
  logic [8:0]  buf_addr_q;
  logic [7:0]  buf_wdata_q;
  logic [8:0]  cnt_q;
  logic [7:0]  tx_q;
  logic        start_q;
  logic [15:0] tmo_q;
  logic        done_s;
  logic [7:0]  rx_s;
  logic        poll_last_s;

  spi_byte_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_q),
    .tx_i    (tx_q),
    .rx_o    (rx_s),
    .done_o  (done_s),
    .sclk_o  (sd_sclk),
    .mosi_o  (sd_mosi),
    .miso_i  (sd_miso)
  );

  // The byte just polled is the last allowed: R1 uses the short NCR window.
  always_comb begin
    if (state_q == ST_R1) begin
      poll_last_s = (tmo_q == (R1_POLL_MAX - 16'd1));
    end else begin
      poll_last_s = (tmo_q == (RESP_TIMEOUT - 16'd1));
    end
  end

  // Transfer FSM: every non-idle state advances on a completed byte and
  // queues the next byte (FF unless the state overrides it).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      is_wr_q     <= 1'b0;
      block_q     <= 23'h000000;
      err_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      buf_we_q    <= 1'b0;
      buf_addr_q  <= 9'd0;
      buf_wdata_q <= 8'h00;
      cnt_q       <= 9'd0;
      tx_q        <= IDLE_BYTE;
      start_q     <= 1'b0;
      tmo_q       <= 16'd0;
    end else begin
      start_q  <= 1'b0;
      buf_we_q <= 1'b0;
      // Address steps past a byte only after its write strobe has been seen.
      if (buf_we_q) begin
        buf_addr_q <= buf_addr_q + 9'd1;
      end
      if (done_s) begin
        start_q <= 1'b1;
        tx_q    <= IDLE_BYTE;
      end
      case (state_q)
        ST_IDLE: begin
          if (card_ready && (read_spi || write_spi)) begin
            is_wr_q    <= write_spi;
            block_q    <= block;
            err_q      <= 1'b0;
            cs_n_q     <= 1'b0;
            buf_addr_q <= 9'd0;
            cnt_q      <= 9'd0;
            start_q    <= 1'b1;
            tx_q       <= write_spi ? CMD24_OP : CMD17_OP;
            state_q    <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (done_s) begin
            if (cnt_q == 9'd5) begin
              state_q <= ST_R1;
              tmo_q   <= 16'd0;
            end else begin
              cnt_q <= cnt_q + 9'd1;
              tx_q  <= cmd_byte(cnt_q[2:0] + 3'd1, is_wr_q, block_q);
            end
          end
        end
        ST_R1: begin
          if (done_s) begin
            if (rx_s == R1_READY) begin
              state_q <= is_wr_q ? ST_WGAP : ST_RTOK;
              tmo_q   <= 16'd0;
            end else if ((rx_s != IDLE_BYTE) || poll_last_s) begin
              state_q <= ST_FIN;
              cs_n_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              tmo_q <= tmo_q + 16'd1;
            end
          end
        end
        ST_RTOK: begin
          if (done_s) begin
            if (rx_s == START_TOKEN) begin
              state_q <= ST_RDATA;
            end else if ((rx_s != IDLE_BYTE) || poll_last_s) begin
              state_q <= ST_FIN;
              cs_n_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              tmo_q <= tmo_q + 16'd1;
            end
          end
        end
        ST_RDATA: begin
          if (done_s) begin
            buf_we_q    <= 1'b1;
            buf_wdata_q <= rx_s;
            // Address 511 written means the 9-bit address wraps: phase over.
            if (buf_addr_q == 9'd511) begin
              state_q <= ST_RCRC;
              cnt_q   <= 9'd0;
            end
          end
        end
        ST_RCRC, ST_WCRC: begin
          if (done_s) begin
            if (cnt_q == 9'd1) begin
              if (state_q == ST_RCRC) begin
                state_q <= ST_FIN;
                cs_n_q  <= 1'b1;
              end else begin
                state_q <= ST_WRESP;
                tmo_q   <= 16'd0;
              end
            end else begin
              cnt_q <= cnt_q + 9'd1;
            end
          end
        end
        ST_WGAP: begin
          if (done_s) begin
            state_q <= ST_WTOK;
            tx_q    <= START_TOKEN;
          end
        end
        ST_WTOK: begin
          // buf_addr has held 0 since capture, so buf_rdata is byte 0 here.
          if (done_s) begin
            state_q    <= ST_WDATA;
            cnt_q      <= 9'd0;
            tx_q       <= buf_rdata;
            buf_addr_q <= 9'd1;
          end
        end
        ST_WDATA: begin
          // The address runs one byte ahead, so the next byte's read data has
          // a whole byte time to settle before it is loaded.
          if (done_s) begin
            if (cnt_q == 9'd511) begin
              state_q    <= ST_WCRC;
              cnt_q      <= 9'd0;
              buf_addr_q <= 9'd0;
            end else begin
              cnt_q      <= cnt_q + 9'd1;
              tx_q       <= buf_rdata;
              buf_addr_q <= buf_addr_q + 9'd1;
            end
          end
        end
        ST_WRESP: begin
          if (done_s) begin
            if (rx_s != IDLE_BYTE) begin
              if ((rx_s & DRESP_MASK) == DRESP_ACCEPT) begin
                state_q <= ST_WBUSY;
                tmo_q   <= 16'd0;
              end else begin
                state_q <= ST_FIN;
                cs_n_q  <= 1'b1;
                err_q   <= 1'b1;
              end
            end else if (poll_last_s) begin
              state_q <= ST_FIN;
              cs_n_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              tmo_q <= tmo_q + 16'd1;
            end
          end
        end
        ST_WBUSY: begin
          if (done_s) begin
            if (rx_s == IDLE_BYTE) begin
              state_q <= ST_FIN;
              cs_n_q  <= 1'b1;
            end else if (poll_last_s) begin
              state_q <= ST_FIN;
              cs_n_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              tmo_q <= tmo_q + 16'd1;
            end
          end
        end
        ST_FIN: begin
          // cs_n is already high; this byte only supplies the trailing clocks.
          if (done_s) begin
            start_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          start_q <= 1'b0;
          cs_n_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = !card_ready || (state_q != ST_IDLE);
  assign err       = err_q;
  assign buf_addr  = buf_addr_q;
  assign buf_wdata = buf_wdata_q;
  assign buf_we    = buf_we_q;
  assign sd_cs_n   = cs_n_q;

endmodule

// File: tb/tb_sd_block_spi.sv
module tb_sd_block_spi;

  localparam int unsigned CLK_DIV      = 2;
  localparam logic [15:0] RESP_TIMEOUT = 16'd16;
  localparam int          WAIT_LIMIT   = 40000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, card_ready, read_spi, write_spi;
  logic [22:0] block;
  logic        busy, err, buf_we, sd_cs_n, sd_sclk, sd_mosi, sd_miso;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_wdata, buf_rdata;

  int n_checks = 0;
  int n_fails  = 0;

  sd_block_spi #(.CLK_DIV(CLK_DIV), .RESP_TIMEOUT(RESP_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .card_ready(card_ready), .read_spi(read_spi),
    .write_spi(write_spi), .block(block), .busy(busy), .err(err),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we),
    .buf_rdata(buf_rdata), .sd_cs_n(sd_cs_n), .sd_sclk(sd_sclk),
    .sd_mosi(sd_mosi), .sd_miso(sd_miso)
  );

  // Block buffer: 1-cycle synchronous read, optional preload of ~i.
  logic [7:0] mem [512];
  bit preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'(~i);
    end else if (buf_we) begin
      mem[buf_addr] <= buf_wdata;
    end
    buf_rdata <= mem[buf_addr];
  end

  // Behavioural SD card (SPI mode 0) plus buffer-write monitor.
  logic [7:0] rx_log [$];
  logic [7:0] plan [$];
  logic [7:0] rx_sr = 8'hFF;
  logic [7:0] tx_sr = 8'hFF;
  logic miso_r = 1'b1, sclk_prev = 1'b0, cs_prev = 1'b1;
  int bc = 0, we_cnt = 0, bad_order = 0, sclk_edges = 0;
  bit force_r1_err = 1'b0, no_token = 1'b0;
  assign sd_miso = miso_r;

  function automatic void fill_plan();
    plan.push_back(8'hFF);
    if (force_r1_err) begin
      plan.push_back(8'h04);
    end else if (rx_log[0] == 8'h51) begin
      plan.push_back(8'h00);
      if (!no_token) begin
        for (int i = 0; i < 3; i++) plan.push_back(8'hFF);
        plan.push_back(8'hFE);
        for (int i = 0; i < 512; i++) plan.push_back(8'(i));
        plan.push_back(8'hA5);
        plan.push_back(8'h5A);
      end
    end else begin
      plan.push_back(8'h00);
      for (int i = 0; i < 516; i++) plan.push_back(8'hFF);
      plan.push_back(8'hE5);
      for (int i = 0; i < 10; i++) plan.push_back(8'h00);
    end
  endfunction

  always @(negedge clk) begin
    if (!sd_cs_n && cs_prev) begin
      rx_log.delete(); plan.delete(); we_cnt = 0; bad_order = 0;
    end
    if (sd_cs_n) begin
      bc = 0; tx_sr = 8'hFF; miso_r = 1'b1;
    end else if (sd_sclk && !sclk_prev) begin
      rx_sr = {rx_sr[6:0], sd_mosi};
      bc++;
      if (bc == 8) begin
        bc = 0;
        rx_log.push_back(rx_sr);
        if (rx_log.size() == 6) fill_plan();
        if (plan.size() > 0) tx_sr = plan.pop_front();
        else tx_sr = 8'hFF;
      end
    end else if (!sd_sclk && sclk_prev) begin
      miso_r = tx_sr[7 - bc];
    end
    if (sd_sclk && !sclk_prev) sclk_edges++;
    if (buf_we) begin
      if (buf_addr !== we_cnt[8:0]) bad_order++;
      we_cnt++;
    end
    sclk_prev = sd_sclk;
    cs_prev   = sd_cs_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < WAIT_LIMIT) begin
      @(negedge clk);
      k++;
    end
    check({tag, " idle within bound"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_cmd(input string tag, input logic [7:0] op, input logic [31:0] arg);
    logic [7:0] exp [6];
    exp = '{op, arg[31:24], arg[23:16], arg[15:8], arg[7:0], 8'hFF};
    for (int i = 0; i < 6; i++)
      check($sformatf("%s cmd byte %0d", tag, i), {24'd0, rx_log[i]}, {24'd0, exp[i]});
  endtask

  initial begin
    int bad, k, e0;
    rst = 1'b1; card_ready = 1'b0; read_spi = 1'b0; write_spi = 1'b0; block = 23'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: reset state, card not ready
    check("t1 busy", {31'd0, busy}, 32'd1);
    check("t1 cs_n", {31'd0, sd_cs_n}, 32'd1);
    check("t1 sclk", {31'd0, sd_sclk}, 32'd0);
    check("t1 mosi", {31'd0, sd_mosi}, 32'd1);
    check("t1 buf_we", {31'd0, buf_we}, 32'd0);
    check("t1 buf_addr", {23'd0, buf_addr}, 32'd0);
    check("t1 err", {31'd0, err}, 32'd0);
    card_ready = 1'b1;
    @(negedge clk);
    check("t1 busy after ready", {31'd0, busy}, 32'd0);

    // 2: block read
    block = 23'h000180; read_spi = 1'b1;
    @(negedge clk);
    check("t2 busy on capture", {31'd0, busy}, 32'd1);
    read_spi = 1'b0;
    wait_idle("t2");
    check("t2 byte count", rx_log.size(), 32'd526);
    check_cmd("t2", 8'h51, 32'h00000180);
    check("t2 we pulses", we_cnt, 32'd512);
    check("t2 addr order", bad_order, 32'd0);
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== 8'(i)) bad++;
    check("t2 buffer data", bad, 32'd0);
    check("t2 err", {31'd0, err}, 32'd0);
    check("t2 cs_n", {31'd0, sd_cs_n}, 32'd1);

    // 3: block write of ~i
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    block = 23'h000200; write_spi = 1'b1;
    @(negedge clk);
    check("t3 busy on capture", {31'd0, busy}, 32'd1);
    write_spi = 1'b0;
    wait_idle("t3");
    check("t3 byte count", rx_log.size(), 32'd536);
    check_cmd("t3", 8'h58, 32'h00000200);
    check("t3 gap byte", {24'd0, rx_log[8]}, 32'hFF);
    check("t3 start token", {24'd0, rx_log[9]}, 32'hFE);
    bad = 0;
    for (int i = 0; i < 512; i++) if (rx_log[10 + i] !== 8'(~i)) bad++;
    check("t3 data bytes", bad, 32'd0);
    check("t3 crc0", {24'd0, rx_log[522]}, 32'hFF);
    check("t3 crc1", {24'd0, rx_log[523]}, 32'hFF);
    check("t3 no buf_we", we_cnt, 32'd0);
    check("t3 err", {31'd0, err}, 32'd0);

    // 4: R1 error
    force_r1_err = 1'b1; block = 23'h000005; read_spi = 1'b1;
    @(negedge clk);
    read_spi = 1'b0;
    wait_idle("t4");
    check("t4 err", {31'd0, err}, 32'd1);
    check("t4 byte count", rx_log.size(), 32'd8);
    check("t4 no buf_we", we_cnt, 32'd0);
    check("t4 cs_n", {31'd0, sd_cs_n}, 32'd1);
    force_r1_err = 1'b0;

    // 5a: start token never arrives; capture clears err
    no_token = 1'b1; read_spi = 1'b1;
    @(negedge clk);
    read_spi = 1'b0;
    check("t5 err cleared on capture", {31'd0, err}, 32'd0);
    wait_idle("t5");
    check("t5 err timeout", {31'd0, err}, 32'd1);
    check("t5 byte count", rx_log.size(), 32'd24);
    no_token = 1'b0;

    // 5b: reset during RDATA
    read_spi = 1'b1;
    @(negedge clk);
    read_spi = 1'b0;
    k = 0;
    while (we_cnt < 3 && k < WAIT_LIMIT) begin @(negedge clk); k++; end
    check("t5 reached RDATA", {31'd0, (we_cnt >= 3)}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5 rst cs_n", {31'd0, sd_cs_n}, 32'd1);
    check("t5 rst buf_we", {31'd0, buf_we}, 32'd0);
    check("t5 rst sclk", {31'd0, sd_sclk}, 32'd0);
    check("t5 rst mosi", {31'd0, sd_mosi}, 32'd1);
    check("t5 rst buf_addr", {23'd0, buf_addr}, 32'd0);
    rst = 1'b0;
    e0 = sclk_edges;
    repeat (200) @(negedge clk);
    check("t5 no sclk after rst", sclk_edges - e0, 32'd0);
    check("t5 idle after rst", {31'd0, busy}, 32'd0);

    // 6: both requests -> CMD24; read held -> second transfer CMD17
    force_r1_err = 1'b1; read_spi = 1'b1; write_spi = 1'b1;
    @(negedge clk);
    check("t6 busy", {31'd0, busy}, 32'd1);
    write_spi = 1'b0;
    wait_idle("t6 first");
    check("t6 first opcode", {24'd0, rx_log[0]}, 32'h58);
    check("t6 first err", {31'd0, err}, 32'd1);
    @(negedge clk);
    check("t6 second capture", {31'd0, busy}, 32'd1);
    read_spi = 1'b0;
    wait_idle("t6 second");
    check("t6 second opcode", {24'd0, rx_log[0]}, 32'h51);
    repeat (50) @(negedge clk);
    check("t6 no third transfer", {31'd0, busy}, 32'd0);
    force_r1_err = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
